// File: rtl/memory_stage.sv
// ============================================================================
// Module   : memory_stage
// Brief    : Data memory, stack pointer and CALL/RET/INT/RTI stack sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_stage #(
    parameter int                ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        stack_op,
    input  logic [15:0]       ALU_out,
    input  logic [15:0]       data2_val,
    input  logic [31:0]       pc_in,
    input  logic [3:0]        flags_in,
    output logic              stall,
    output logic [15:0]       mem_out,
    output logic              mem_out_valid,
    output logic [31:0]       pc_out,
    output logic              pc_valid,
    output logic [3:0]        mem_flags,
    output logic              flags_valid,
    output logic [ADDR_W-1:0] sp_out
);

    localparam logic [2:0] C_OP_PUSH = 3'd1;
    localparam logic [2:0] C_OP_POP  = 3'd2;
    localparam logic [2:0] C_OP_CALL = 3'd3;
    localparam logic [2:0] C_OP_RET  = 3'd4;
    localparam logic [2:0] C_OP_INT  = 3'd5;
    localparam logic [2:0] C_OP_RTI  = 3'd6;
    localparam logic [ADDR_W-1:0] C_SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT2 = 2'd1,
        S_BEAT3 = 2'd2
    } state_t;

    logic [15:0]       mem [2**ADDR_W];
    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [15:0]       pc_lo_q;

    logic [2:0]        w_op;
    logic              w_active, w_multi, w_three, w_idle;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr, w_raddr, w_sp_inc;
    logic [15:0]       w_wdata, w_rdata;
    logic              w_load, w_pc_lo, w_pc_done, w_flags_ld, w_flags_done;
    logic              w_unused_ok;

    assign w_unused_ok = &{1'b0, ALU_out[15:ADDR_W]};

    always_comb begin
        w_idle   = (state_q == S_IDLE);
        w_op     = w_idle ? stack_op : op_q;
        w_multi  = (w_op == C_OP_CALL) || (w_op == C_OP_RET) ||
                   (w_op == C_OP_INT)  || (w_op == C_OP_RTI);
        w_three  = (w_op == C_OP_INT)  || (w_op == C_OP_RTI);
        w_active = !w_idle || in_valid;
        stall    = w_active && w_multi &&
                   (w_idle || ((state_q == S_BEAT2) && w_three));

        w_sp_inc     = sp_q + C_SP_ONE;
        sp_d         = sp_q;
        w_we         = 1'b0;
        w_waddr      = sp_q;
        w_wdata      = 16'h0000;
        w_raddr      = ALU_out[ADDR_W-1:0];
        w_load       = 1'b0;
        w_pc_lo      = 1'b0;
        w_pc_done    = 1'b0;
        w_flags_ld   = 1'b0;
        w_flags_done = 1'b0;
        state_d      = state_q;

        if (w_active) begin
            case (w_op)
                C_OP_PUSH: begin
                    w_we    = 1'b1;
                    w_wdata = data2_val;
                    sp_d    = sp_q - C_SP_ONE;
                end
                C_OP_POP: begin
                    w_raddr = w_sp_inc;
                    w_load  = 1'b1;
                    sp_d    = w_sp_inc;
                end
                C_OP_CALL, C_OP_INT: begin
                    w_we = 1'b1;
                    sp_d = sp_q - C_SP_ONE;
                    case (state_q)
                        S_IDLE:  w_wdata = pc_in[31:16];
                        S_BEAT2: w_wdata = pc_in[15:0];
                        default: w_wdata = {12'h000, flags_in};
                    endcase
                end
                C_OP_RET, C_OP_RTI: begin
                    w_raddr = w_sp_inc;
                    sp_d    = w_sp_inc;
                    // RTI pops flags first, so its PC pops run one beat later than RET's
                    if (w_op == C_OP_RTI && w_idle) begin
                        w_flags_ld = 1'b1;
                    end else if ((w_op == C_OP_RET && w_idle) ||
                                 (w_op == C_OP_RTI && state_q == S_BEAT2)) begin
                        w_pc_lo = 1'b1;
                    end else begin
                        w_pc_done    = 1'b1;
                        w_flags_done = (w_op == C_OP_RTI);
                    end
                end
                default: begin
                    if (mem_write) begin
                        w_we    = 1'b1;
                        w_waddr = ALU_out[ADDR_W-1:0];
                        w_wdata = data2_val;
                    end else if (mem_read) begin
                        w_load = 1'b1;
                    end
                end
            endcase

            case (state_q)
                S_IDLE:  state_d = w_multi ? S_BEAT2 : S_IDLE;
                S_BEAT2: state_d = w_three ? S_BEAT3 : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        w_rdata = mem[w_raddr];
    end

    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= 3'd0;
            sp_q          <= SP_RESET;
            pc_lo_q       <= 16'h0000;
            mem_out       <= 16'h0000;
            mem_out_valid <= 1'b0;
            pc_out        <= 32'h0000_0000;
            pc_valid      <= 1'b0;
            mem_flags     <= 4'h0;
            flags_valid   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            mem_out_valid <= w_load;
            pc_valid      <= w_pc_done;
            flags_valid   <= w_flags_done;
            if (w_idle) begin
                op_q <= stack_op;
            end
            if (w_load) begin
                mem_out <= w_rdata;
            end
            if (w_pc_lo) begin
                pc_lo_q <= w_rdata;
            end
            if (w_pc_done) begin
                pc_out <= {w_rdata, pc_lo_q};
            end
            if (w_flags_ld) begin
                mem_flags <= w_rdata[3:0];
            end
        end
    end

    assign sp_out = sp_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// Module   : tb_memory_stage
// Brief    : Directed scoreboard bench for memory_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_read, mem_write;
    logic [2:0]  stack_op;
    logic [15:0] ALU_out, data2_val;
    logic [31:0] pc_in;
    logic [3:0]  flags_in;
    logic        stall, mem_out_valid, pc_valid, flags_valid;
    logic [15:0] mem_out;
    logic [31:0] pc_out;
    logic [3:0]  mem_flags;
    logic [10:0] sp_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        has_flags;
        logic [3:0]  flags;
    } pc_exp_t;

    logic [15:0] exp_mem_q [$];
    pc_exp_t     exp_pc_q  [$];

    memory_stage #(.ADDR_W(11), .SP_RESET(11'h7FF)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .stack_op(stack_op), .ALU_out(ALU_out),
        .data2_val(data2_val), .pc_in(pc_in), .flags_in(flags_in),
        .stall(stall), .mem_out(mem_out), .mem_out_valid(mem_out_valid),
        .pc_out(pc_out), .pc_valid(pc_valid), .mem_flags(mem_flags),
        .flags_valid(flags_valid), .sp_out(sp_out)
    );

    always #5 clk = ~clk;

    // Monitor: compares every output pulse against the queued expectation
    always @(negedge clk) begin
        if (mem_out_valid) begin
            checks++;
            if (exp_mem_q.size() == 0) begin
                errors++;
                $display("FAIL mem_out_unexpected got %h required no pulse", mem_out);
            end else begin
                logic [15:0] e;
                e = exp_mem_q.pop_front();
                if (mem_out !== e) begin
                    errors++;
                    $display("FAIL mem_out got %h required %h", mem_out, e);
                end
            end
        end
        if (pc_valid) begin
            checks++;
            if (exp_pc_q.size() == 0) begin
                errors++;
                $display("FAIL pc_unexpected got %h required no pulse", pc_out);
            end else begin
                pc_exp_t e;
                e = exp_pc_q.pop_front();
                if (pc_out !== e.pc || flags_valid !== e.has_flags ||
                    (e.has_flags && mem_flags !== e.flags)) begin
                    errors++;
                    $display("FAIL pc_out got %h fv=%b fl=%h required %h fv=%b fl=%h",
                             pc_out, flags_valid, mem_flags, e.pc, e.has_flags, e.flags);
                end
            end
        end else if (flags_valid) begin
            checks++;
            errors++;
            $display("FAIL flags_valid_alone got 1 required 0");
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; stack_op = 3'd0;
        ALU_out = 16'h0; data2_val = 16'h0; pc_in = 32'h0; flags_in = 4'h0;
    endtask

    // Drives one request for `beats` cycles, checking stall on every beat
    task automatic do_op(input logic [2:0] sop, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] data,
                         input logic [31:0] pc, input logic [3:0] fl, input int beats);
        @(negedge clk);
        in_valid = 1'b1; stack_op = sop; mem_read = rd; mem_write = wr;
        ALU_out = addr; data2_val = data; pc_in = pc; flags_in = fl;
        for (int b = 1; b <= beats; b++) begin
            #1;
            check($sformatf("stall_beat%0d_op%0d", b, sop), {31'b0, stall}, {31'b0, b < beats});
            if (b < beats) @(negedge clk);
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        do_op(3'd0, 1'b0, 1'b1, a, d, 32'h0, 4'h0, 1);
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] e);
        exp_mem_q.push_back(e);
        do_op(3'd0, 1'b1, 1'b0, a, 16'h0, 32'h0, 4'h0, 1);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_sp", {21'b0, sp_out}, 32'h7FF);
        check("rst_mem_out", {16'b0, mem_out}, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_flags", {28'b0, mem_flags}, 32'h0);
        check("rst_valids", {29'b0, mem_out_valid, pc_valid, flags_valid}, 32'h0);

        store(16'h0010, 16'hBEEF);
        load(16'h0010, 16'hBEEF);
        check("sp_after_ldst", {21'b0, sp_out}, 32'h7FF);

        do_op(3'd1, 1'b0, 1'b0, 16'h0, 16'h1234, 32'h0, 4'h0, 1);
        check("sp_push1", {21'b0, sp_out}, 32'h7FE);
        do_op(3'd1, 1'b0, 1'b0, 16'h0, 16'h5678, 32'h0, 4'h0, 1);
        check("sp_push2", {21'b0, sp_out}, 32'h7FD);
        exp_mem_q.push_back(16'h5678);
        do_op(3'd2, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 4'h0, 1);
        check("sp_pop1", {21'b0, sp_out}, 32'h7FE);
        exp_mem_q.push_back(16'h1234);
        do_op(3'd2, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 4'h0, 1);
        check("sp_pop2", {21'b0, sp_out}, 32'h7FF);

        do_op(3'd3, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0001_0200, 4'h0, 2);
        check("sp_call", {21'b0, sp_out}, 32'h7FD);
        load(16'h07FF, 16'h0001);
        load(16'h07FE, 16'h0200);
        exp_pc_q.push_back('{pc: 32'h0001_0200, has_flags: 1'b0, flags: 4'h0});
        do_op(3'd4, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 4'h0, 2);
        check("sp_ret", {21'b0, sp_out}, 32'h7FF);
        load(16'h0010, 16'hBEEF);

        do_op(3'd5, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0000_00A0, 4'b1010, 3);
        check("sp_int", {21'b0, sp_out}, 32'h7FC);
        load(16'h07FD, 16'h000A);
        exp_pc_q.push_back('{pc: 32'h0000_00A0, has_flags: 1'b1, flags: 4'b1010});
        do_op(3'd6, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 4'h0, 3);
        check("sp_rti", {21'b0, sp_out}, 32'h7FF);

        // stack_op beats the store when both are requested
        do_op(3'd1, 1'b0, 1'b1, 16'h0020, 16'h4444, 32'h0, 4'h0, 1);
        check("sp_push_prio", {21'b0, sp_out}, 32'h7FE);
        exp_mem_q.push_back(16'h4444);
        do_op(3'd2, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 4'h0, 1);
        do_op(3'd0, 1'b1, 1'b1, 16'h0020, 16'h7777, 32'h0, 4'h0, 1);
        load(16'h0020, 16'h7777);

        store(16'h0000, 16'hA5A5);
        exp_mem_q.push_back(16'hA5A5);
        do_op(3'd2, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 4'h0, 1);
        check("sp_pop_wrap", {21'b0, sp_out}, 32'h000);
        do_op(3'd1, 1'b0, 1'b0, 16'h0, 16'h00FF, 32'h0, 4'h0, 1);
        check("sp_push_wrap", {21'b0, sp_out}, 32'h7FF);
        load(16'h0000, 16'h00FF);

        @(negedge clk);
        in_valid = 1'b0; mem_write = 1'b1; ALU_out = 16'h0000; data2_val = 16'h1111;
        @(posedge clk);
        #1 clear_inputs();
        check("sp_idle", {21'b0, sp_out}, 32'h7FF);
        load(16'h0000, 16'h00FF);

        @(negedge clk);
        in_valid = 1'b1; stack_op = 3'd5; pc_in = 32'hCAFE_0000; flags_in = 4'h3;
        @(negedge clk);
        check("int_beat2_stall", {31'b0, stall}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #1;
        check("rst_mid_sp", {21'b0, sp_out}, 32'h7FF);
        check("rst_mid_stall", {31'b0, stall}, 32'h0);
        load(16'h07FF, 16'hCAFE);

        repeat (3) @(negedge clk);
        check("mem_queue_empty", exp_mem_q.size(), 32'h0);
        check("pc_queue_empty", exp_pc_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running required finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
